// File: rtl/counter_4b.sv
// 4-bit saturating up/down counter with a loadable upper limit.
// Only the at-limit and at-zero decodes of the count leave the block.
module counter_4b (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_en,
  input  logic       count_dec,
  input  logic       count_inc,
  input  logic [3:0] count_to,
  output logic       flag_max,
  output logic       flag_min
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic [3:0] lim_q;
  logic [3:0] lim_d;

  // A load takes priority and clamps the count into the new range.
  // Opposing step requests cancel each other out.
  always_comb begin
    cnt_d = cnt_q;
    lim_d = lim_q;
    if (load_en) begin
      lim_d = count_to;
      if (cnt_q > count_to) begin
        cnt_d = count_to;
      end
    end else if (count_inc && !count_dec) begin
      if (cnt_q < lim_q) begin
        cnt_d = cnt_q + 4'd1;
      end
    end else if (count_dec && !count_inc) begin
      if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 4'd0;
      lim_q <= 4'hF;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end

  // Flags decode registered state only, so they cannot glitch with the inputs.
  assign flag_max = (cnt_q == lim_q);
  assign flag_min = (cnt_q == 4'd0);

endmodule

// File: tb/tb_counter_4b.sv
// Self-checking bench for counter_4b: a reference model pushes expected
// flags into a queue per driven cycle, popped and compared after each edge.
module tb_counter_4b;

  logic       clk;
  logic       reset_n;
  logic       load_en;
  logic       count_dec;
  logic       count_inc;
  logic [3:0] count_to;
  logic       flag_max;
  logic       flag_min;

  int checkCount = 0;
  int errorCount = 0;

  logic [3:0] modelCnt;
  logic [3:0] modelLim;
  logic [1:0] expQueue[$];

  counter_4b dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_en   (load_en),
    .count_dec (count_dec),
    .count_inc (count_inc),
    .count_to  (count_to),
    .flag_max  (flag_max),
    .flag_min  (flag_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [1:0] observed,
                             input logic [1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: flags {max,min} got %b expected %b at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle at the falling edge, advance the model, and check the
  // flags just after the capturing rising edge.
  task automatic applyStimulus(input string tag, input logic ld, input logic inc,
                               input logic dec, input logic [3:0] to);
    logic [1:0] expected;
    @(negedge clk);
    load_en   = ld;
    count_inc = inc;
    count_dec = dec;
    count_to  = to;
    if (ld) begin
      modelLim = to;
      if (modelCnt > to) modelCnt = to;
    end else if (inc && !dec) begin
      if (modelCnt < modelLim) modelCnt = modelCnt + 4'd1;
    end else if (dec && !inc) begin
      if (modelCnt != 4'd0) modelCnt = modelCnt - 4'd1;
    end
    expQueue.push_back({modelCnt == modelLim, modelCnt == 4'd0});
    @(posedge clk);
    #1;
    expected = expQueue.pop_front();
    checkOutput(tag, {flag_max, flag_min}, expected);
    load_en   = 1'b0;
    count_inc = 1'b0;
    count_dec = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    checkOutput("reset_assert", {flag_max, flag_min}, 2'b01);
    @(negedge clk);
    reset_n  = 1'b1;
    modelCnt = 4'd0;
    modelLim = 4'hF;
  endtask

  initial begin
    reset_n   = 1'b0;
    load_en   = 1'b1;
    count_inc = 1'b0;
    count_dec = 1'b0;
    count_to  = 4'h3;
    modelCnt  = 4'd0;
    modelLim  = 4'hF;

    // Load strobe held during reset must be ignored.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_flags", {flag_max, flag_min}, 2'b01);
    @(negedge clk);
    reset_n = 1'b1;
    load_en = 1'b0;
    applyStimulus("reset_idle", 1'b0, 1'b0, 1'b0, 4'h0);

    // Default limit 15: max after edge 15, no wrap.
    for (int i = 0; i < 20; i++) applyStimulus("inc_default", 1'b0, 1'b1, 1'b0, 4'h0);

    doReset();
    applyStimulus("load5", 1'b1, 1'b0, 1'b0, 4'h5);
    for (int i = 0; i < 7; i++) applyStimulus("inc_to5", 1'b0, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 6; i++) applyStimulus("dec_to0", 1'b0, 1'b0, 1'b1, 4'h0);

    doReset();
    for (int i = 0; i < 12; i++) applyStimulus("inc_to12", 1'b0, 1'b1, 1'b0, 4'h0);
    applyStimulus("clamp_load7", 1'b1, 1'b0, 1'b0, 4'h7);
    for (int i = 0; i < 4; i++) applyStimulus("dec_to3", 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus("inc_dec_both", 1'b0, 1'b1, 1'b1, 4'h0);
    applyStimulus("load_beats_inc", 1'b1, 1'b1, 1'b0, 4'h4);
    applyStimulus("inc_after_load", 1'b0, 1'b1, 1'b0, 4'h0);

    applyStimulus("load_lim0", 1'b1, 1'b0, 1'b0, 4'h0);
    applyStimulus("lim0_inc", 1'b0, 1'b1, 1'b0, 4'h0);
    applyStimulus("lim0_dec", 1'b0, 1'b0, 1'b1, 4'h0);

    // Asynchronous pulse between edges at count 9.
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus("inc_to9", 1'b0, 1'b1, 1'b0, 4'h0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset", {flag_max, flag_min}, 2'b01);
    #1;
    reset_n  = 1'b1;
    modelCnt = 4'd0;
    modelLim = 4'hF;
    for (int i = 0; i < 3; i++) applyStimulus("resume_inc", 1'b0, 1'b1, 1'b0, 4'h0);

    for (int i = 0; i < 60; i++) begin
      applyStimulus("random",
                    ($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)));
    end

    $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
